// File: rtl/dtw_sample_tx.sv
// Host-side sample transmitter for the DTW core: buffers 30-bit feature vectors
// in a FIFO and emits one framed SEQ_LEN-word sequence per start command.
//
// state | meaning
// IDLE  | waiting for start; flush honoured here
// SEND  | presenting FIFO head with o_valid=1, popping on each accepted word
// DONE  | one-cycle o_seq_done pulse, then back to IDLE
module dtw_sample_tx #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int SEQ_LEN = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_wr_en,
  input  logic [29:0]   i_wr_data,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  input  logic          i_flush,
  input  logic          i_start,
  output logic          o_start_err,
  output logic          o_busy,
  output logic [31:0]   o_Sin,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_seq_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam int          SEQ_LAST_I = SEQ_LEN - 1;
  localparam logic [AW:0] DEPTH_W    = DEPTH[AW:0];
  localparam logic [AW:0] SEQ_LEN_W  = SEQ_LEN[AW:0];
  localparam logic [AW:0] SEQ_LAST_W = SEQ_LAST_I[AW:0];
  localparam logic [AW:0] CNT_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [29:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [AW:0]     word_cnt, word_cnt_nxt;
  logic            start_err_nxt;
  logic            flush, push, pop, last;

  assign o_full     = (count == DEPTH_W);
  assign o_count    = count;
  assign o_busy     = (state != IDLE);
  assign o_valid    = (state == SEND);
  assign o_seq_done = (state == DONE);
  assign last       = (word_cnt == SEQ_LAST_W);
  assign o_Sin      = {o_valid && (word_cnt == '0), o_valid && last, mem[rd_ptr]};

  assign flush = i_flush && (state == IDLE);
  assign pop   = o_valid && i_ready;
  assign push  = i_wr_en && !o_full && !flush;

  always_comb begin
    state_nxt     = state;
    word_cnt_nxt  = word_cnt;
    start_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        // A coincident flush empties the FIFO, so it also refuses the start.
        if (i_start) begin
          if (count >= SEQ_LEN_W && !i_flush) begin
            state_nxt    = SEND;
            word_cnt_nxt = '0;
          end else begin
            start_err_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (pop) begin
          word_cnt_nxt = word_cnt + CNT_ONE;
          if (last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_start_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      word_cnt    <= word_cnt_nxt;
      o_start_err <= start_err_nxt;
      // A write discarded by a flush is not an overflow.
      o_overflow  <= i_wr_en && o_full && !flush;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

endmodule

// File: tb/tb_dtw_sample_tx.sv
// Directed plus randomized bench for dtw_sample_tx, checked against a queue-based
// model of the FIFO and the framing rules.
module tb_dtw_sample_tx;
  localparam int DEPTH = 32;
  localparam int SEQ   = 32;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [29:0] i_wr_data = '0;
  logic        i_flush = 1'b0;
  logic        i_start = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_full, o_overflow, o_start_err, o_busy, o_valid, o_seq_done;
  logic [5:0]  o_count;
  logic [31:0] o_Sin;

  dtw_sample_tx #(.DEPTH(DEPTH), .AW(5), .SEQ_LEN(SEQ)) dut (
    .clk(clk), .nrst(nrst),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_full(o_full), .o_count(o_count), .o_overflow(o_overflow),
    .i_flush(i_flush), .i_start(i_start), .o_start_err(o_start_err),
    .o_busy(o_busy), .o_Sin(o_Sin), .o_valid(o_valid),
    .i_ready(i_ready), .o_seq_done(o_seq_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [29:0] q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [29:0] d);
    bit full;
    full = (q.size() == DEPTH);
    i_wr_en = 1'b1;
    i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
    if (!full) q.push_back(d);
    check("wr_overflow", {31'd0, o_overflow}, {31'd0, full});
    check("wr_count", {26'd0, o_count}, q.size());
  endtask

  task automatic fill();
    while (q.size() < DEPTH) write_word(30'($urandom));
    check("fill_full", {31'd0, o_full}, 32'd1);
  endtask

  task automatic start_ok();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_err_ok", {31'd0, o_start_err}, 32'd0);
    check("start_busy", {31'd0, o_busy}, 32'd1);
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready + writes;
  // 3: always ready with an ignored flush+start at word 3.
  task automatic run_seq(input int mode, input int k0);
    int k, cyc;
    bit rdy, wr, full;
    logic [29:0] d;
    logic [31:0] exp;
    k = k0;
    cyc = 0;
    while (k < SEQ && cyc < 400) begin
      exp = {k == 0, k == SEQ - 1, q[0]};
      check("valid", {31'd0, o_valid}, 32'd1);
      check("sin", o_Sin, exp);
      check("count_send", {26'd0, o_count}, q.size());
      check("seq_done_early", {31'd0, o_seq_done}, 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      wr = (mode == 2) && ($urandom_range(0, 3) == 0);
      d = 30'($urandom);
      full = (q.size() == DEPTH);
      i_ready = rdy;
      i_wr_en = wr;
      i_wr_data = d;
      i_flush = (mode == 3) && (k == 3);
      i_start = i_flush;
      tick();
      i_wr_en = 1'b0;
      i_flush = 1'b0;
      i_start = 1'b0;
      if (rdy) begin
        void'(q.pop_front());
        k++;
      end
      if (wr && !full) q.push_back(d);
      check("overflow_send", {31'd0, o_overflow}, {31'd0, wr && full});
      check("start_err_send", {31'd0, o_start_err}, 32'd0);
      cyc++;
    end
    i_ready = 1'b0;
    check("seq_budget", k, SEQ);
    check("done_pulse", {31'd0, o_seq_done}, 32'd1);
    check("valid_done", {31'd0, o_valid}, 32'd0);
    check("busy_done", {31'd0, o_busy}, 32'd1);
    tick();
    check("done_clear", {31'd0, o_seq_done}, 32'd0);
    check("busy_idle", {31'd0, o_busy}, 32'd0);
    check("count_after", {26'd0, o_count}, q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_count", {26'd0, o_count}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_flags", {26'd0, o_full, o_overflow, o_start_err, o_seq_done, o_Sin[31:30]}, 32'd0);
    nrst = 1'b1;
    tick();

    // Words 0..31, continuous acceptance
    for (int i = 0; i < SEQ; i++) write_word(30'(i));
    start_ok();
    check("word0", o_Sin, 32'h8000_0000);
    run_seq(0, 0);

    // Short FIFO: start refused
    for (int i = 0; i < 10; i++) write_word(30'($urandom));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_err", {31'd0, o_start_err}, 32'd1);
    check("start_err_idle", {31'd0, o_busy}, 32'd0);
    check("start_err_count", {26'd0, o_count}, 32'd10);
    tick();
    check("start_err_pulse", {31'd0, o_start_err}, 32'd0);

    // Stalled handshake
    fill();
    start_ok();
    run_seq(1, 0);

    // Overflow when full, including push during a pop
    fill();
    write_word(30'h3FFF_FFFF);
    tick();
    check("overflow_pulse", {31'd0, o_overflow}, 32'd0);
    start_ok();
    i_ready = 1'b1;
    i_wr_en = 1'b1;
    i_wr_data = 30'h0123_4567;
    tick();
    i_wr_en = 1'b0;
    void'(q.pop_front());
    check("overflow_pop", {31'd0, o_overflow}, 32'd1);
    check("overflow_pop_count", {26'd0, o_count}, q.size());
    run_seq(2, 1);

    // Reset mid-sequence
    fill();
    start_ok();
    i_ready = 1'b1;
    repeat (5) begin
      tick();
      void'(q.pop_front());
    end
    check("mid_sin", o_Sin, {2'b00, q[0]});
    nrst = 1'b0;
    tick();
    q.delete();
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_count", {26'd0, o_count}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    nrst = 1'b1;
    i_ready = 1'b0;
    tick();

    // Flush/start ignored in SEND, then flush honoured in IDLE
    fill();
    start_ok();
    run_seq(3, 0);
    for (int i = 0; i < 3; i++) write_word(30'($urandom));
    i_flush = 1'b1;
    i_wr_en = 1'b1;
    i_wr_data = 30'h2AAA_AAAA;
    tick();
    i_flush = 1'b0;
    i_wr_en = 1'b0;
    q.delete();
    check("flush_count", {26'd0, o_count}, 32'd0);
    check("flush_overflow", {31'd0, o_overflow}, 32'd0);

    // Random ready and traffic
    fill();
    start_ok();
    run_seq(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
